// File: rtl/c_pipe_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package c_pipe_pkg;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    // Forwarding select for one EX source operand; the MEM stage is newer, so it wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs_e,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            return FWD_MEM;
        end
        if (we_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/c_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module c_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment unless already saturated; synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/c_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipe: load-use stalls, branch flushes,
// data-memory wait freeze with timeout/error, operand forwarding and perf counters.
module c_hazard_ctrl
    import c_pipe_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WAIT_ONE   = WCNT_W'(1);

    hz_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_stall;
    logic lw_stall;

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic: enter MEM_WAIT on an unanswered request, time out into sticky ERR.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Hazard detection terms; the memory freeze acts in the same cycle the request is seen.
    always_comb begin
        mem_stall = (MemReqM && !MemReadyM && (state_q != ERR)) || (state_q == ERR);
        lw_stall  = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Output decode: memory freeze beats branch flush beats load-use stall; all low in reset.
    always_comb begin
        ForwardAE = FWD_REG;
        ForwardBE = FWD_REG;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        MemErr    = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            MemErr    = (state_q == ERR);
            if (mem_stall) begin
                // Whole pipe holds; a pending branch flush waits for the release cycle.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
            end
        end
    end

    c_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (StallCnt)
    );

    c_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushD),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_c_hazard_ctrl.sv
// Scoreboard bench for c_hazard_ctrl: driver queues hand-computed expectations,
// a monitor on the falling edge pops and compares them.
module tb_c_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [15:0] StallCnt, FlushCnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];

    always #5 clk = ~clk;

    c_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .ResultSrcE (ResultSrcE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .PCSrcE     (PCSrcE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .MemErr     (MemErr),
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
    );

    // {FA, FB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
    function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic me);
        return {fa, fb, sf, sd, se, sm, fd, fe, fw, me};
    endfunction

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input string nm, input logic [11:0] ctl,
                        input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.ctl = ctl; e.sc = sc; e.fc = fc;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    // Monitor: outputs are valid every cycle, compare on the falling edge.
    initial begin
        exp_t        e;
        string       nm;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                       FlushD, FlushE, FlushW, MemErr};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: got %b expected %b", nm, act, e.ctl);
                end
                checks++;
                if (StallCnt !== e.sc) begin
                    errors++;
                    $display("FAIL %s StallCnt: got %0d expected %0d", nm, StallCnt, e.sc);
                end
                checks++;
                if (FlushCnt !== e.fc) begin
                    errors++;
                    $display("FAIL %s FlushCnt: got %0d expected %0d", nm, FlushCnt, e.fc);
                end
                $display("txn %-12s ctl=%b sc=%0d fc=%0d", nm, act, StallCnt, FlushCnt);
            end
        end
    end

    localparam logic [11:0] IDLE = 12'b0;

    initial begin
        clr();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset masks every combinational output even with hazards on the inputs.
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; PCSrcE = 1; MemReqM = 1;
        RegWriteM = 1; RdM = 3; Rs1E = 3;
        step("reset_out", IDLE, 16'd0, 16'd0);
        reset = 1'b0;
        clr();
        step("idle", IDLE, 0, 0);

        // Load-use hazards
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        step("lw_rs1", mk(0,0,1,1,0,0,0,1,0,0), 0, 0);
        clr();
        step("after_lw", IDLE, 1, 0);
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        step("lw_x0", IDLE, 1, 0);
        ResultSrcE = 2'b01; RdE = 6; Rs2D = 6;
        step("lw_rs2", mk(0,0,1,1,0,0,0,1,0,0), 1, 0);
        clr();
        step("idle2", IDLE, 2, 0);

        // Branch flush, alone and together with a load-use stall
        PCSrcE = 1;
        step("branch", mk(0,0,0,0,0,0,1,1,0,0), 2, 0);
        clr();
        step("after_br", IDLE, 2, 1);
        PCSrcE = 1; ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        step("br_and_lw", mk(0,0,1,1,0,0,1,1,0,0), 2, 1);
        clr();
        step("idle3", IDLE, 3, 2);

        // Forwarding
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 0;
        step("fwd_mem", mk(2'b10,2'b00,0,0,0,0,0,0,0,0), 3, 2);
        RegWriteM = 0; Rs2E = 7;
        step("fwd_wb", mk(2'b01,2'b01,0,0,0,0,0,0,0,0), 3, 2);
        RegWriteM = 1; RdW = 0; Rs1E = 9; Rs2E = 7;
        step("fwd_b_mem", mk(2'b00,2'b10,0,0,0,0,0,0,0,0), 3, 2);
        clr();

        // Memory wait of three stalled cycles, released on the fourth
        MemReqM = 1; MemReadyM = 0;
        step("mw1", mk(0,0,1,1,1,1,0,0,1,0), 3, 2);
        step("mw2", mk(0,0,1,1,1,1,0,0,1,0), 4, 2);
        step("mw3", mk(0,0,1,1,1,1,0,0,1,0), 5, 2);
        MemReadyM = 1;
        step("mw_ready", IDLE, 6, 2);
        clr();
        step("mw_run", IDLE, 6, 2);

        // Branch held during a memory wait flushes only on the release cycle
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1; RegWriteM = 1; RdM = 7; Rs1E = 7;
        step("mwbr1", mk(2'b10,0,1,1,1,1,0,0,1,0), 6, 2);
        step("mwbr2", mk(2'b10,0,1,1,1,1,0,0,1,0), 7, 2);
        MemReadyM = 1;
        step("mwbr_rel", mk(2'b10,0,0,0,0,0,1,1,0,0), 8, 2);
        clr();
        step("idle4", IDLE, 8, 3);

        // Timeout: 16 stalled cycles, then ERR
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 16; i++) begin
            step($sformatf("to_%0d", i + 1), mk(0,0,1,1,1,1,0,0,1,0), 16'(8 + i), 3);
        end
        step("err", mk(0,0,1,1,1,1,0,0,1,1), 24, 3);
        MemReqM = 0; MemReadyM = 1; PCSrcE = 1;
        step("err_sticky", mk(0,0,1,1,1,1,0,0,1,1), 25, 3);
        reset = 1'b1;
        step("err_reset", IDLE, 26, 3);
        reset = 1'b0;
        clr();
        step("post_reset", IDLE, 0, 0);
        MemReqM = 1; MemReadyM = 1;
        step("req_ready", IDLE, 0, 0);

        // Saturation: stay stalled for more than 2^16 cycles
        MemReadyM = 0;
        repeat (65536 + 3) @(posedge clk);
        #1;
        step("sat1", mk(0,0,1,1,1,1,0,0,1,1), 16'hFFFF, 0);
        step("sat2", mk(0,0,1,1,1,1,0,0,1,1), 16'hFFFF, 0);
        reset = 1'b1;
        step("sat_reset", IDLE, 16'hFFFF, 0);
        reset = 1'b0;
        clr();
        step("final_idle", IDLE, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
